tdc_multi_core: RTL and testbench

Multi-channel time-over-threshold (ToT) and timestamp converter for MONHIT-style discriminator inputs. It is the parametrised successor of the single-channel TDC core: N channels instead of one, per-channel enable, an optional rising-edge timestamp word, and per-channel loss accounting. It sits between the LEMO/MONHIT inputs and the shared readout FIFO arbiter, and emits 32-bit words through a FIFO-style pop interface.

---
 rtl/tdc_multi_core.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_tdc_multi_core.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_multi_core.sv
`default_nettype none
// ============================================================================
// Module   : tdc_multi_core
// Purpose  : Multi-channel time-over-threshold (ToT) and timestamp converter.
//            Each channel synchronizes its discriminator input, measures
//            how long the synchronized level stays high, and stores the
//            result (plus an optional rising-edge timestamp word) in a
//            two-word channel buffer. A round-robin arbiter moves whole
//            events from the channel buffers into a single output register
//            that is read through a FIFO-style pop interface.
// Ports    : BUS_CLK    - single clock, also used for input sampling
//            BUS_RST    - synchronous active-high reset
//            TDC_IN     - asynchronous discriminator inputs, one per channel
//            EN         - per-channel enable (level)
//            TS_EN      - emit a timestamp word after each ToT word
//            CLR_CNT    - one-cycle pulse, clears event and lost counters
//            FIFO_READ  - pop strobe, honoured only while FIFO_EMPTY is 0
//            FIFO_EMPTY - 0 when FIFO_DATA holds a valid word
//            FIFO_DATA  - output word
//            LOST_CNT   - per-channel lost-event counters, 8 bits each
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module tdc_multi_core #(
  parameter int         CHANNELS = 4,
  parameter logic [3:0] HEADER   = 4'b0100
) (
  input  logic                    BUS_CLK,
  input  logic                    BUS_RST,
  input  logic [CHANNELS-1:0]     TDC_IN,
  input  logic [CHANNELS-1:0]     EN,
  input  logic                    TS_EN,
  input  logic                    CLR_CNT,
  input  logic                    FIFO_READ,
  output logic                    FIFO_EMPTY,
  output logic [31:0]             FIFO_DATA,
  output logic [8*CHANNELS-1:0]   LOST_CNT
);

  localparam int          c_ch_w     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [11:0] c_tot_max  = 12'hFFF;
  localparam logic [7:0]  c_lost_max = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Free-running timestamp counter, wraps naturally at 2^23.
  logic [22:0]         ts_cnt_q, ts_cnt_d;

  // Channel buffer heads as seen by the arbiter.
  logic [CHANNELS-1:0] w_head_valid;
  logic [CHANNELS-1:0] w_head_is_b;
  logic [31:0]         w_head_word [CHANNELS];
  logic [CHANNELS-1:0] w_pop;

  // Arbiter and output register.
  logic [c_ch_w-1:0]   ptr_q, ptr_d;
  logic [c_ch_w-1:0]   w_prev;
  logic [c_ch_w-1:0]   w_grant;
  logic                w_grant_valid;
  logic                w_load;
  int                  w_idx;
  logic                out_valid_q, out_valid_d;
  logic [31:0]         out_data_q, out_data_d;

  assign ts_cnt_d = ts_cnt_q + 23'd1;

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      ts_cnt_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel input path, measurement FSM, counters and two-word buffer
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic        sync1_q, sync2_q, s_prev_q;
    state_t      state_q, state_d;
    logic [11:0] tot_q, tot_d;
    logic [22:0] ts_q, ts_d;
    logic        two_q, two_d;
    logic [10:0] evt_q, evt_d;
    logic [7:0]  lost_q, lost_d;
    logic [31:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        w_rise, w_fall, w_push, w_room, w_store, w_drop;
    logic [1:0]  w_need;
    logic [31:0] w_word_a, w_word_b;

    assign w_rise   = sync2_q & ~s_prev_q;
    assign w_fall   = ~sync2_q & s_prev_q;
    assign w_need   = two_q ? 2'd2 : 2'd1;
    // Room is judged on the occupancy before any same-cycle pop.
    assign w_room   = (w_need <= (2'd2 - cnt_q));
    assign w_store  = w_push & w_room;
    assign w_drop   = w_push & ~w_room;
    assign w_word_a = {HEADER, 4'(gi), 1'b0, evt_q, tot_q};
    assign w_word_b = {HEADER, 4'(gi), 1'b1, ts_q};

    assign w_head_valid[gi] = (cnt_q != 2'd0);
    assign w_head_is_b[gi]  = (cnt_q != 2'd0) & buf0_q[23];
    assign w_head_word[gi]  = buf0_q;
    assign LOST_CNT[8*gi +: 8] = lost_q;

    always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        s_prev_q <= 1'b0;
      end else begin
        sync1_q  <= TDC_IN[gi];
        sync2_q  <= sync1_q;
        s_prev_q <= sync2_q;
      end
    end

    always_comb begin
      state_d = state_q;
      tot_d   = tot_q;
      ts_d    = ts_q;
      two_d   = two_q;
      w_push  = 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Only a fresh edge starts a measurement, so enabling a channel
          // whose input is already high waits for the next rising edge.
          if (w_rise && EN[gi]) begin
            state_d = ST_HIGH;
            tot_d   = 12'd1;
            ts_d    = ts_cnt_q;
            two_d   = TS_EN;
          end
        end
        ST_HIGH: begin
          if (!EN[gi]) begin
            state_d = ST_IDLE;
          end else if (w_fall) begin
            // The buffer write is issued on the falling-edge cycle so the
            // word lands in the buffer while the FSM sits in DONE.
            state_d = ST_DONE;
            w_push  = 1'b1;
          end else if (tot_q != c_tot_max) begin
            tot_d = tot_q + 12'd1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    always_comb begin
      buf0_d = buf0_q;
      buf1_d = buf1_q;
      cnt_d  = cnt_q;
      if (w_pop[gi]) begin
        buf0_d = buf1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      if (w_store) begin
        if (two_q) begin
          // A two-word event only fits into an empty buffer, so no pop
          // can be in flight here.
          buf0_d = w_word_a;
          buf1_d = w_word_b;
          cnt_d  = 2'd2;
        end else if (cnt_d == 2'd0) begin
          buf0_d = w_word_a;
          cnt_d  = 2'd1;
        end else begin
          buf1_d = w_word_a;
          cnt_d  = 2'd2;
        end
      end
    end

    always_comb begin
      evt_d  = evt_q;
      lost_d = lost_q;
      if (CLR_CNT) begin
        evt_d  = '0;
        lost_d = '0;
      end else begin
        if (w_store) begin
          evt_d = evt_q + 11'd1;
        end
        if (w_drop && (lost_q != c_lost_max)) begin
          lost_d = lost_q + 8'd1;
        end
      end
    end

    always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
        state_q <= ST_IDLE;
        tot_q   <= '0;
        ts_q    <= '0;
        two_q   <= 1'b0;
        evt_q   <= '0;
        lost_q  <= '0;
        buf0_q  <= '0;
        buf1_q  <= '0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        tot_q   <= tot_d;
        ts_q    <= ts_d;
        two_q   <= two_d;
        evt_q   <= evt_d;
        lost_q  <= lost_d;
        buf0_q  <= buf0_d;
        buf1_q  <= buf1_d;
        cnt_q   <= cnt_d;
      end
    end
  end : g_ch

  // --------------------------------------------------------------------------
  // Round-robin arbiter. ptr_q is the first channel to consider; the channel
  // just before it was granted last. A word B at the head of that channel is
  // the second half of an event in progress and must go next.
  // --------------------------------------------------------------------------
  always_comb begin
    w_prev        = (ptr_q == '0) ? c_ch_w'(CHANNELS - 1) : (ptr_q - 1'b1);
    w_grant       = ptr_q;
    w_grant_valid = 1'b0;
    w_idx         = 0;
    if (w_head_is_b[w_prev]) begin
      w_grant       = w_prev;
      w_grant_valid = 1'b1;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        w_idx = int'(ptr_q) + k;
        if (w_idx >= CHANNELS) begin
          w_idx = w_idx - CHANNELS;
        end
        if (!w_grant_valid && w_head_valid[w_idx]) begin
          w_grant       = c_ch_w'(w_idx);
          w_grant_valid = 1'b1;
        end
      end
    end
  end

  // Output register refills when empty or in the same cycle it is popped.
  assign w_load = ~out_valid_q | FIFO_READ;

  always_comb begin
    w_pop       = '0;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (w_load && w_grant_valid) begin
      w_pop[w_grant] = 1'b1;
      out_valid_d    = 1'b1;
      out_data_d     = w_head_word[w_grant];
      ptr_d          = (w_grant == c_ch_w'(CHANNELS - 1)) ? '0 : (w_grant + 1'b1);
    end else if (FIFO_READ && out_valid_q) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign FIFO_EMPTY = ~out_valid_q;
  assign FIFO_DATA  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_tdc_multi_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdc_multi_core
// Purpose  : Self-checking bench for tdc_multi_core. Pulse tasks compute the
//            expected words from pulse length, start cycle and per-channel
//            event counts and queue them; a monitor matches every popped
//            word against that queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdc_multi_core;

  localparam int         CH  = 4;
  localparam logic [3:0] HDR = 4'b0100;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CH-1:0]   tdc_in = '0;
  logic [CH-1:0]   en = '0;
  logic            ts_en = 1'b0;
  logic            clr_cnt = 1'b0;
  logic            fifo_read = 1'b0;
  logic            fifo_empty;
  logic [31:0]     fifo_data;
  logic [8*CH-1:0] lost_cnt;

  tdc_multi_core #(.CHANNELS(CH), .HEADER(HDR)) dut (
    .BUS_CLK   (clk),
    .BUS_RST   (rst),
    .TDC_IN    (tdc_in),
    .EN        (en),
    .TS_EN     (ts_en),
    .CLR_CNT   (clr_cnt),
    .FIFO_READ (fifo_read),
    .FIFO_EMPTY(fifo_empty),
    .FIFO_DATA (fifo_data),
    .LOST_CNT  (lost_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [31:0] w;
    bit          two;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] obs_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          evt_m [CH];
  int          lost_m[CH];
  longint      edge_n = 0;
  bit          pend_b = 1'b0;
  int          pend_ch = 0;
  bit          rand_run = 1'b0;

  // Edges seen since reset released == value of the DUT timestamp counter.
  always @(posedge clk) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  // Monitor: every accepted pop is matched against the expected queue.
  logic [31:0] mon_got;
  int          mon_ch;
  int          mon_idx;
  always @(negedge clk) begin
    if (!rst && !fifo_empty && fifo_read) begin
      mon_got = fifo_data;
      mon_ch  = int'(mon_got[27:24]);
      obs_q.push_back(mon_got);
      if (pend_b) begin
        n_checks++;
        if (mon_ch != pend_ch || !mon_got[23]) begin
          n_fail++;
          $display("FAIL b_follows_a: got ch %0d type %0d, required ch %0d type 1",
                   mon_ch, mon_got[23], pend_ch);
        end
      end
      mon_idx = -1;
      foreach (exp_q[k]) if (mon_idx < 0 && exp_q[k].ch == mon_ch) mon_idx = k;
      n_checks++;
      if (mon_idx < 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got %h, required no word", mon_got);
        pend_b = 1'b0;
      end else begin
        if (exp_q[mon_idx].w !== mon_got) begin
          n_fail++;
          $display("FAIL word_ch%0d: got %h required %h", mon_ch, mon_got, exp_q[mon_idx].w);
        end
        pend_b  = !exp_q[mon_idx].w[23] && exp_q[mon_idx].two;
        pend_ch = mon_ch;
        exp_q.delete(mon_idx);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic chk_lost(input string name);
    logic [8*CH-1:0] e;
    for (int i = 0; i < CH; i++) e[8*i +: 8] = 8'(lost_m[i]);
    chk(name, 64'(lost_cnt), 64'(e));
  endtask

  task automatic clear_model();
    exp_q.delete();
    obs_q.delete();
    pend_b = 1'b0;
    for (int i = 0; i < CH; i++) begin
      evt_m[i]  = 0;
      lost_m[i] = 0;
    end
  endtask

  task automatic do_reset();
    tdc_in = '0;
    rst    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
  endtask

  // mode 0: event stored, 1: event lost for lack of room, 2: event aborted
  task automatic pulse(input int ch, input int hi, input int mode);
    longint      n0;
    bit          two;
    int          tot;
    logic [31:0] wa, wb;
    tdc_in[ch] = 1'b1;
    n0  = edge_n;
    two = ts_en;
    repeat (hi) @(posedge clk);
    #1;
    tdc_in[ch] = 1'b0;
    if (mode == 0) begin
      tot = (hi > 4095) ? 4095 : hi;
      wa  = {HDR, 4'(ch), 1'b0, 11'(evt_m[ch]), 12'(tot)};
      exp_q.push_back('{ch, wa, two});
      if (two) begin
        // Synchronizer delay of two edges between drive and detected rise.
        wb = {HDR, 4'(ch), 1'b1, 23'(n0 + 2)};
        exp_q.push_back('{ch, wb, 1'b1});
      end
      evt_m[ch] = (evt_m[ch] + 1) % 2048;
    end else if (mode == 1) begin
      lost_m[ch] = (lost_m[ch] < 255) ? lost_m[ch] + 1 : 255;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || !fifo_empty) && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_empty"}, 64'(fifo_empty), 64'd1);
  endtask

  task automatic rand_chan(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(40, 80));
      pulse(ch, $urandom_range(1, 30), 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_empty", 64'(fifo_empty), 64'd1);
    chk("rst_data", 64'(fifo_data), 64'd0);
    chk("rst_lost", 64'(lost_cnt), 64'd0);
    en = '1;

    // Single pulse with latency check on FIFO_EMPTY.
    fifo_read = 1'b1;
    pulse(2, 150, 0);
    idle(3);
    chk("lat_still_empty", 64'(fifo_empty), 64'd1);
    idle(1);
    chk("lat_word_ready", 64'(fifo_empty), 64'd0);
    wait_drain("single");

    // Timestamp mode, two pulses on channel 0.
    ts_en = 1'b1;
    pulse(0, 5, 0);
    idle(6);
    pulse(0, 7, 0);
    wait_drain("ts_pair");

    // TS_EN dropped mid-event: word count fixed at the rising edge.
    fork
      pulse(2, 12, 0);
      begin idle(5); ts_en = 1'b0; end
    join
    wait_drain("ts_toggle");

    // All channels fall together; order 0,1,2,3 from a fresh pointer.
    do_reset();
    ts_en = 1'b1;
    fork
      pulse(0, 10, 0);
      pulse(1, 10, 0);
      pulse(2, 10, 0);
      pulse(3, 10, 0);
    join
    wait_drain("simul");
    chk("simul_count", 64'(obs_q.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < obs_q.size()) begin
        chk($sformatf("simul_order%0d", i),
            64'({obs_q[i][27:24], obs_q[i][23]}), 64'({4'(i / 2), 1'(i % 2)}));
      end
    end

    // Loss accounting with reads stalled.
    do_reset();
    ts_en     = 1'b0;
    fifo_read = 1'b0;
    pulse(1, 3, 0); idle(6);
    pulse(1, 3, 0); idle(6);
    pulse(1, 3, 0); idle(6);
    pulse(1, 3, 1); idle(10);
    chk_lost("lost_one");
    fifo_read = 1'b1;
    wait_drain("lost_drain");
    chk_lost("lost_hold");

    // Saturating ToT.
    pulse(3, 5000, 0);
    wait_drain("tot_sat");

    // EN dropped mid-pulse: nothing emitted.
    obs_q.delete();
    fork
      pulse(0, 40, 2);
      begin idle(20); en[0] = 1'b0; end
    join
    en[0] = 1'b1;
    idle(20);
    // Enabling while input already high does not start a measurement.
    en[1] = 1'b0;
    tdc_in[1] = 1'b1;
    idle(6);
    en[1] = 1'b1;
    idle(10);
    tdc_in[1] = 1'b0;
    idle(20);
    chk("abort_no_words", 64'(obs_q.size()), 64'd0);
    chk("abort_empty", 64'(fifo_empty), 64'd1);

    // Counter clear.
    clr_cnt = 1'b1;
    idle(1);
    clr_cnt = 1'b0;
    for (int i = 0; i < CH; i++) begin
      evt_m[i]  = 0;
      lost_m[i] = 0;
    end
    chk_lost("clr_lost");
    pulse(3, 4, 0);
    wait_drain("clr_evt");

    // Randomized traffic, both word formats.
    for (int r = 0; r < 2; r++) begin
      ts_en    = r[0];
      rand_run = 1'b1;
      fork
        begin
          while (rand_run) begin
            @(posedge clk);
            #1;
            fifo_read = ($urandom_range(0, 3) != 0);
          end
          fifo_read = 1'b1;
        end
        begin
          fork
            rand_chan(0, 6);
            rand_chan(1, 6);
            rand_chan(2, 6);
            rand_chan(3, 6);
          join
          rand_run = 1'b0;
        end
      join
      wait_drain($sformatf("rand%0d", r));
      chk_lost($sformatf("rand%0d_lost", r));
    end

    // Reset while two words are pending.
    fifo_read = 1'b0;
    ts_en     = 1'b1;
    pulse(0, 4, 0);
    idle(6);
    chk("pend_present", 64'(fifo_empty), 64'd0);
    rst = 1'b1;
    idle(1);
    chk("midrst_empty", 64'(fifo_empty), 64'd1);
    chk("midrst_data", 64'(fifo_data), 64'd0);
    idle(1);
    rst = 1'b0;
    clear_model();
    fifo_read = 1'b1;
    idle(30);
    chk("no_stale_words", 64'(obs_q.size()), 64'd0);
    chk("final_pending", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
